dmem_wb_master: RTL and testbench
=================================

Name: dmem_wb_master

Overview:
- Wishbone B4 classic master between the pipeline's MEM stage and data memory.
- Replaces the fixed full-word, ACK-ignored memory hookup.
- Adds byte/halfword/word access with sign or zero extension, lane select generation, misalignment detection, and a pipeline stall held until ACK.
- Adds a bus timeout that reports an error instead of hanging the core.

Parameters:
ADDR_W, 32, width of the byte address and ADR_O.
TIMEOUT, 16, cycles in BUS without ACK_I/ERR_I before abort; 0 disables the timeout.
CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  synchronous, active-high reset.
mem_read  in  1  load request from MEM stage.
mem_write  in  1  store request; wins if mem_read is also high.
mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
mem_unsigned  in  1  1 = zero-extend loads, 0 = sign-extend.
addr  in  ADDR_W  byte address.
wdata  in  32  store data, right-justified.
rdata  out  32  extended load data; valid in the DONE cycle.
stall  out  1  freezes the pipeline while high.
misalign  out  1  one-cycle pulse for a misaligned request.
bus_err  out  1  one-cycle pulse when ERR_I is seen or the timeout fires.
ADR_O  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}.
DAT_O  out  32  lane-replicated store data.
DAT_I  in  32  read data from slave.
WE_O  out  1  write enable.
SEL_O  out  4  byte-lane select.
STB_O  out  1  strobe.
CYC_O  out  1  cycle.
ACK_I  in  1  slave acknowledge.
ERR_I  in  1  slave error.

Behaviour:
- req = mem_read | mem_write.
- Alignment: aligned = (size byte) | (half & !addr[0]) | (word & addr[1:0]==0).
- FSM states IDLE, BUS, DONE. Reset: state IDLE, counter 0, all outputs 0.
- IDLE:
  - req & aligned: stall=1 combinationally; register ADR_O/DAT_O/SEL_O/WE_O; next state BUS.
  - req & !aligned: misalign=1 and stall=0 this cycle; no bus cycle; write suppressed; rdata=0; stay IDLE.
- BUS:
  - CYC_O=STB_O=1 and stall=1.
  - ADR_O/DAT_O/SEL_O/WE_O held stable.
  - Counter increments every cycle.
  - ACK_I=1: capture the extended load into rdata, go DONE.
  - ERR_I=1 (priority over ACK_I): rdata=0, bus_err=1 in DONE.
  - TIMEOUT!=0 and counter==TIMEOUT-1 with no ACK_I/ERR_I: abort and treat as ERR.
  - CYC_O/STB_O drop on the edge leaving BUS.
- DONE:
  - stall=0 and rdata valid; bus_err pulses here if flagged.
  - The request inputs still held by the pipeline are ignored.
  - Next state IDLE, counter cleared.
- Latency: minimum 2 stall cycles (request cycle plus one BUS cycle with same-cycle ACK). Each wait state adds 1.
- SEL_O:
  - byte: 4'b0001<<addr[1:0]
  - half: addr[1] ? 4'b1100 : 4'b0011
  - word: 4'b1111
- DAT_O:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extraction: the selected lane of DAT_I, shifted to bit 0, then extended to 32 bits per mem_unsigned. Word loads are passed through.
- Little-endian: byte lane k = DAT_I[8k+7:8k].
- reset while in BUS: CYC_O/STB_O low after that edge, state IDLE; no rdata, bus_err, or misalign pulse.
- ACK_I/ERR_I arriving while in IDLE or DONE are ignored.
- rdata holds its last value outside DONE.

Test Plan:
- Aligned sw of 0xDEADBEEF to 0x10, ACK_I in first BUS cycle -> stall high exactly 2 cycles, SEL_O=1111, WE_O=1, DAT_O=0xDEADBEEF, ADR_O=0x10.
- DAT_I=0x80F17F02: lb at 0x3 -> rdata 0xFFFFFF80; lbu at 0x3 -> 0x00000080; lh at 0x2 -> 0xFFFF80F1; lhu at 0x0 -> 0x00007F02. SEL_O=1000, 1000, 1100, 0011 respectively.
- sb of 0xAB at 0x21 -> SEL_O=0010, DAT_O=0xABABABAB, ADR_O=0x20. sh of 0x1234 at 0x22 -> SEL_O=1100, DAT_O=0x12341234.
- lw at 0x6 -> misalign pulse 1 cycle, stall never high, CYC_O never high. sh at 0x5 -> same.
- Slave never acks, TIMEOUT=16 -> CYC_O high 16 cycles, then DONE with bus_err=1, rdata=0, stall low. ERR_I on 3rd BUS cycle -> bus_err in the following cycle.
- reset asserted on 2nd BUS cycle -> CYC_O=0 next cycle, stall=0, no bus_err. A new lw after reset completes normally.

Source files
------------

// File: rtl/dmem_wb_master.sv
// Wishbone B4 classic master for MEM-stage loads/stores: lane select, sign/zero
// extension, misalignment detection, pipeline stall until ACK, and a bus timeout.
module dmem_wb_master #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [1:0]        mem_size,
    input  logic              mem_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata,
    output logic              stall,
    output logic              misalign,
    output logic              bus_err,
    output logic [ADDR_W-1:0] ADR_O,
    output logic [31:0]       DAT_O,
    input  logic [31:0]       DAT_I,
    output logic              WE_O,
    output logic [3:0]        SEL_O,
    output logic              STB_O,
    output logic              CYC_O,
    input  logic              ACK_I,
    input  logic              ERR_I
);
    // state | meaning
    // IDLE  | waiting for a request; aligned requests launch the bus cycle
    // BUS   | CYC/STB asserted, waiting for ACK, ERR or timeout
    // DONE  | result presented for one cycle, pipeline released
    typedef enum logic [1:0] {S_IDLE, S_BUS, S_DONE} state_t;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       size_q;
    logic [1:0]       lo_q;
    logic             uns_q;
    logic             err_q;
    logic             req, aligned, timeout_hit;
    logic [3:0]       sel_nxt;
    logic [31:0]      dat_nxt, shifted, load_ext;

    assign req         = mem_read | mem_write;
    assign timeout_hit = (TIMEOUT != 0) && (cnt == TO_LAST);
    assign CYC_O       = (state == S_BUS);
    assign STB_O       = (state == S_BUS);
    assign bus_err     = (state == S_DONE) && err_q;

    always_comb begin
        aligned = 1'b0;
        sel_nxt = 4'b1111;
        dat_nxt = wdata;
        case (mem_size)
            2'b00: begin
                aligned = 1'b1;
                sel_nxt = 4'b0001 << addr[1:0];
                dat_nxt = {4{wdata[7:0]}};
            end
            2'b01: begin
                aligned = !addr[0];
                sel_nxt = addr[1] ? 4'b1100 : 4'b0011;
                dat_nxt = {2{wdata[15:0]}};
            end
            default: aligned = (addr[1:0] == 2'b00);
        endcase
    end

    // Selected lane is shifted down to bit 0 before extension.
    always_comb begin
        shifted  = DAT_I >> {lo_q, 3'b000};
        load_ext = DAT_I;
        case (size_q)
            2'b00:   load_ext = uns_q ? {24'b0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = uns_q ? {16'b0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = DAT_I;
        endcase
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        misalign  = 1'b0;
        case (state)
            S_IDLE: begin
                if (req && aligned) begin
                    stall     = 1'b1;
                    state_nxt = S_BUS;
                end else if (req) begin
                    misalign = 1'b1;
                end
            end
            S_BUS: begin
                stall = 1'b1;
                if (ERR_I || ACK_I || timeout_hit)
                    state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            ADR_O  <= '0;
            DAT_O  <= '0;
            SEL_O  <= '0;
            WE_O   <= 1'b0;
            size_q <= '0;
            lo_q   <= '0;
            uns_q  <= 1'b0;
            err_q  <= 1'b0;
            rdata  <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    cnt <= '0;
                    if (req && aligned) begin
                        ADR_O  <= {addr[ADDR_W-1:2], 2'b00};
                        DAT_O  <= dat_nxt;
                        SEL_O  <= sel_nxt;
                        WE_O   <= mem_write;
                        size_q <= mem_size;
                        lo_q   <= addr[1:0];
                        uns_q  <= mem_unsigned;
                    end else if (req) begin
                        rdata <= '0;
                    end
                end
                S_BUS: begin
                    cnt <= cnt + 1'b1;
                    // ERR wins over ACK; a timeout is reported as an error.
                    if (ERR_I || (!ACK_I && timeout_hit)) begin
                        rdata <= '0;
                        err_q <= 1'b1;
                    end else if (ACK_I) begin
                        rdata <= load_ext;
                    end
                end
                default: begin
                    cnt   <= '0;
                    err_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_wb_master.sv
// Directed testbench for dmem_wb_master with a per-cycle scripted slave.
module tb_dmem_wb_master;
    logic        clk = 1'b0;
    logic        reset;
    logic        mem_read, mem_write, mem_unsigned;
    logic [1:0]  mem_size;
    logic [31:0] addr, wdata, rdata, DAT_O, DAT_I, ADR_O;
    logic        stall, misalign, bus_err, WE_O, STB_O, CYC_O, ACK_I, ERR_I;
    logic [3:0]  SEL_O;

    int checks = 0;
    int errors = 0;

    dmem_wb_master #(.ADDR_W(32), .TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
        .mem_size(mem_size), .mem_unsigned(mem_unsigned), .addr(addr),
        .wdata(wdata), .rdata(rdata), .stall(stall), .misalign(misalign),
        .bus_err(bus_err), .ADR_O(ADR_O), .DAT_O(DAT_O), .DAT_I(DAT_I),
        .WE_O(WE_O), .SEL_O(SEL_O), .STB_O(STB_O), .CYC_O(CYC_O),
        .ACK_I(ACK_I), .ERR_I(ERR_I)
    );

    always #5 clk = ~clk;

    // Observations from one access; comparisons happen in the calling test.
    int          o_stall, o_cyc;
    logic [31:0] o_rdata, o_dato, o_adr;
    logic [3:0]  o_sel;
    logic        o_we, o_berr, o_mis, o_done;

    task automatic run_access(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] di, input int ack_at, input int err_at);
        o_stall = 0; o_cyc = 0; o_rdata = 'x; o_dato = '0; o_adr = '0;
        o_sel = '0; o_we = 1'b0; o_berr = 1'b0; o_mis = 1'b0; o_done = 1'b0;
        @(negedge clk);
        mem_write = we; mem_read = !we; mem_size = size; mem_unsigned = uns;
        addr = a; wdata = wd; DAT_I = di; ACK_I = 1'b0; ERR_I = 1'b0;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (stall) o_stall++;
            if (misalign) o_mis = 1'b1;
            if (CYC_O) begin
                o_sel = SEL_O; o_dato = DAT_O; o_adr = ADR_O; o_we = WE_O;
                ACK_I = (o_cyc == ack_at);
                ERR_I = (o_cyc == err_at);
                o_cyc++;
            end else begin
                ACK_I = 1'b0; ERR_I = 1'b0;
            end
            if (!stall && !CYC_O) begin
                o_rdata = rdata; o_berr = bus_err; o_done = 1'b1;
                mem_read = 1'b0; mem_write = 1'b0;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!o_done) begin
            errors++;
            $display("FAIL access_timeout: access at %h never completed", a);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_read = 0; mem_write = 0; mem_size = 0; mem_unsigned = 0;
        addr = 0; wdata = 0; DAT_I = 0; ACK_I = 0; ERR_I = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({CYC_O, STB_O, stall, misalign, bus_err, WE_O} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 000000", {CYC_O, STB_O, stall, misalign, bus_err, WE_O});
        end
        checks++;
        if ({rdata, ADR_O, DAT_O, SEL_O} !== 100'b0) begin
            errors++;
            $display("FAIL reset_data: rdata %h adr %h dat %h sel %b want zeros", rdata, ADR_O, DAT_O, SEL_O);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_store_word();
        run_access(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 0, -1);
        checks++;
        if (o_stall !== 2) begin errors++; $display("FAIL sw_stall: got %0d want 2", o_stall); end
        checks++;
        if ({o_sel, o_we} !== 5'b11111) begin errors++; $display("FAIL sw_sel_we: got %b %b want 1111 1", o_sel, o_we); end
        checks++;
        if (o_dato !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_dat: got %h want deadbeef", o_dato); end
        checks++;
        if (o_adr !== 32'h10) begin errors++; $display("FAIL sw_adr: got %h want 00000010", o_adr); end
    endtask

    task automatic test_loads();
        logic [31:0] a_v [5]  = '{32'h3, 32'h3, 32'h2, 32'h0, 32'h4};
        logic [1:0]  s_v [5]  = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        logic        u_v [5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [31:0] r_v [5]  = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80F1, 32'h00007F02, 32'h80F17F02};
        logic [3:0]  sl_v [5] = '{4'b1000, 4'b1000, 4'b1100, 4'b0011, 4'b1111};
        int          w_v [5]  = '{0, 0, 1, 0, 2};
        for (int i = 0; i < 5; i++) begin
            run_access(1'b0, s_v[i], u_v[i], a_v[i], 32'h0, 32'h80F17F02, w_v[i], -1);
            checks++;
            if (o_rdata !== r_v[i]) begin errors++; $display("FAIL load%0d_rdata: got %h want %h", i, o_rdata, r_v[i]); end
            checks++;
            if ({o_sel, o_we} !== {sl_v[i], 1'b0}) begin errors++; $display("FAIL load%0d_sel: got %b we %b want %b we 0", i, o_sel, o_we, sl_v[i]); end
            checks++;
            if (o_stall !== 2 + w_v[i]) begin errors++; $display("FAIL load%0d_stall: got %0d want %0d", i, o_stall, 2 + w_v[i]); end
        end
    endtask

    task automatic test_sub_stores();
        run_access(1'b1, 2'b00, 1'b0, 32'h21, 32'h123456AB, 32'h0, 0, -1);
        checks++;
        if ({o_sel, o_dato, o_adr} !== {4'b0010, 32'hABABABAB, 32'h20}) begin
            errors++; $display("FAIL sb_lanes: sel %b dat %h adr %h want 0010 abababab 00000020", o_sel, o_dato, o_adr);
        end
        run_access(1'b1, 2'b01, 1'b0, 32'h22, 32'hFFFF1234, 32'h0, 0, -1);
        checks++;
        if ({o_sel, o_dato, o_adr} !== {4'b1100, 32'h12341234, 32'h20}) begin
            errors++; $display("FAIL sh_lanes: sel %b dat %h adr %h want 1100 12341234 00000020", o_sel, o_dato, o_adr);
        end
    endtask

    task automatic test_misalign();
        logic        we_v [2] = '{1'b0, 1'b1};
        logic [1:0]  s_v [2]  = '{2'b10, 2'b01};
        logic [31:0] a_v [2]  = '{32'h6, 32'h5};
        for (int i = 0; i < 2; i++) begin
            run_access(we_v[i], s_v[i], 1'b0, a_v[i], 32'h5555, 32'h0, 0, -1);
            @(negedge clk); #1;
            checks++;
            if ({o_mis, o_stall != 0, o_cyc != 0, misalign, CYC_O} !== 5'b10000) begin
                errors++;
                $display("FAIL misalign%0d: mis %b stall %0d cyc %0d later_mis %b later_cyc %b want 1 0 0 0 0",
                         i, o_mis, o_stall, o_cyc, misalign, CYC_O);
            end
        end
    endtask

    task automatic test_timeout_err();
        run_access(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, 32'h11223344, -1, -1);
        checks++;
        if (o_cyc !== 16 || o_stall !== 17) begin errors++; $display("FAIL timeout_len: cyc %0d stall %0d want 16 17", o_cyc, o_stall); end
        checks++;
        if ({o_berr, o_rdata} !== {1'b1, 32'h0}) begin errors++; $display("FAIL timeout_err: berr %b rdata %h want 1 00000000", o_berr, o_rdata); end
        run_access(1'b0, 2'b10, 1'b0, 32'h44, 32'h0, 32'h55667788, 0, -1);
        checks++;
        if ({o_berr, o_rdata} !== {1'b0, 32'h55667788}) begin errors++; $display("FAIL post_timeout: berr %b rdata %h want 0 55667788", o_berr, o_rdata); end
        // ERR and ACK together on the third BUS cycle: ERR wins.
        run_access(1'b0, 2'b10, 1'b0, 32'h48, 32'h0, 32'h99AABBCC, 2, 2);
        checks++;
        if ({o_cyc == 3, o_berr, o_rdata} !== {1'b1, 1'b1, 32'h0}) begin
            errors++; $display("FAIL err_resp: cyc %0d berr %b rdata %h want 3 1 00000000", o_cyc, o_berr, o_rdata);
        end
        @(negedge clk); #1;
        checks++;
        if (bus_err !== 1'b0) begin errors++; $display("FAIL err_pulse_width: bus_err %b want 0", bus_err); end
    endtask

    task automatic test_reset_in_bus();
        @(negedge clk);
        mem_read = 1'b1; mem_write = 1'b0; mem_size = 2'b10; addr = 32'h80; DAT_I = 32'hCAFEF00D;
        ACK_I = 1'b0; ERR_I = 1'b0;
        @(negedge clk); // first BUS cycle
        @(negedge clk); // second BUS cycle
        #1;
        checks++;
        if (CYC_O !== 1'b1) begin errors++; $display("FAIL rst_bus_pre: CYC_O %b want 1", CYC_O); end
        reset = 1'b1; mem_read = 1'b0;
        @(negedge clk); #1;
        checks++;
        if ({CYC_O, STB_O, stall, bus_err, misalign} !== 5'b0) begin
            errors++; $display("FAIL rst_bus_post: cyc stb stall err mis %b want 00000", {CYC_O, STB_O, stall, bus_err, misalign});
        end
        reset = 1'b0;
        run_access(1'b0, 2'b10, 1'b0, 32'h84, 32'h0, 32'h0BADC0DE, 1, -1);
        checks++;
        if ({o_berr, o_rdata, o_stall} !== {1'b0, 32'h0BADC0DE, 3}) begin
            errors++; $display("FAIL rst_bus_after: berr %b rdata %h stall %0d want 0 0badc0de 3", o_berr, o_rdata, o_stall);
        end
    endtask

    initial begin
        test_reset();
        test_store_word();
        test_loads();
        test_sub_stores();
        test_misalign();
        test_timeout_err();
        test_reset_in_bus();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
